conv_seq_ctrl: RTL and testbench

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences a KxK convolution window over an IMG_W x IMG_H image.
// Coefficients are loaded first, then one tap is streamed per cycle from SRAM
// with the matching coefficient and the output pixel coordinate.
// Optional feature: define CONV_ZEROPAD_EN to zero-pad out-of-image taps
// (no SRAM read, pixel 0). Without it, border taps replicate the edge pixel.
module conv_seq_ctrl #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int K     = 5,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int AW    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         fc_valid,
  input  logic signed [CW-1:0]         fc,
  output logic                         sram_rd,
  output logic [AW-1:0]                sram_addr,
  input  logic [DW-1:0]                sram_rdata,
  output logic                         win_valid,
  output logic [DW-1:0]                win_pixel,
  output logic signed [CW-1:0]         win_coef,
  output logic                         win_first,
  output logic                         win_last,
  output logic [$clog2(IMG_W)-1:0]     out_x,
  output logic [$clog2(IMG_H)-1:0]     out_y,
  output logic                         busy,
  output logic                         done
);

  localparam int NTAP = K * K;
  localparam int HALF = K / 2;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int MW   = $clog2(K + 1);
  localparam int TW   = $clog2(NTAP + 1);
  localparam int CRDW = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H) + 2;

  localparam logic signed [CRDW-1:0] ROW_MAX = CRDW'(IMG_H - 1);
  localparam logic signed [CRDW-1:0] COL_MAX = CRDW'(IMG_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_COEF,
    FETCH,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   coefCnt_q, coefCnt_d;
  logic [XW-1:0]   xCnt_q, xCnt_d;
  logic [YW-1:0]   yCnt_q, yCnt_d;
  logic [MW-1:0]   mCnt_q, mCnt_d;
  logic [MW-1:0]   nCnt_q, nCnt_d;
  logic [TW-1:0]   tapCnt_q, tapCnt_d;
  logic            drain_q, drain_d;

  logic signed [CW-1:0] coef_q [NTAP];

  logic                 winValid_q;
  logic                 winFirst_q;
  logic                 winLast_q;
  logic signed [CW-1:0] winCoef_q;
  logic [XW-1:0]        outX_q;
  logic [YW-1:0]        outY_q;

  logic                  tapActive;
  logic                  issue;
  logic signed [CRDW-1:0] rowS;
  logic signed [CRDW-1:0] colS;
  logic [CRDW-1:0]       rowC;
  logic [CRDW-1:0]       colC;
  logic [AW-1:0]         tapAddr;

  // A tap is presented to SRAM every FETCH cycle except the final drain cycle;
  // it only survives into the window pipeline while start is still held.
  assign tapActive = (state_q == FETCH) && !drain_q;
  assign issue     = tapActive && start;

  // Source coordinate of the current tap, kept signed so that negative
  // offsets near the top/left border are detected instead of wrapping.
  assign rowS = CRDW'(yCnt_q) + CRDW'(mCnt_q) - CRDW'(HALF);
  assign colS = CRDW'(xCnt_q) + CRDW'(nCnt_q) - CRDW'(HALF);

  // Clamp the source coordinate into the image (edge replicate).
  always_comb begin
    rowC = rowS;
    colC = colS;
    if (rowS[CRDW-1]) begin
      rowC = '0;
    end else if (rowS > ROW_MAX) begin
      rowC = ROW_MAX;
    end
    if (colS[CRDW-1]) begin
      colC = '0;
    end else if (colS > COL_MAX) begin
      colC = COL_MAX;
    end
  end

  assign tapAddr   = AW'(rowC) * AW'(IMG_W) + AW'(colC);
  assign sram_addr = tapActive ? tapAddr : '0;

`ifdef CONV_ZEROPAD_EN
  logic tapOob;
  logic winPad_q;

  assign tapOob = rowS[CRDW-1] || (rowS > ROW_MAX) ||
                  colS[CRDW-1] || (colS > COL_MAX);
  assign sram_rd   = tapActive && !tapOob;
  assign win_pixel = (winValid_q && !winPad_q) ? sram_rdata : '0;

  // Remember whether the tap now in flight was outside the image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winPad_q <= 1'b0;
    end else begin
      winPad_q <= issue && tapOob;
    end
  end
`else
  assign sram_rd   = tapActive;
  assign win_pixel = winValid_q ? sram_rdata : '0;
`endif

  // Control state and scan counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      coefCnt_q <= '0;
      xCnt_q    <= '0;
      yCnt_q    <= '0;
      mCnt_q    <= '0;
      nCnt_q    <= '0;
      tapCnt_q  <= '0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      coefCnt_q <= coefCnt_d;
      xCnt_q    <= xCnt_d;
      yCnt_q    <= yCnt_d;
      mCnt_q    <= mCnt_d;
      nCnt_q    <= nCnt_d;
      tapCnt_q  <= tapCnt_d;
      drain_q   <= drain_d;
    end
  end

  // Next-state logic; counters fall back to zero in any state that does not own them.
  always_comb begin
    state_d   = state_q;
    coefCnt_d = '0;
    xCnt_d    = '0;
    yCnt_d    = '0;
    mCnt_d    = '0;
    nCnt_d    = '0;
    tapCnt_d  = '0;
    drain_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_COEF;
      end
      LOAD_COEF: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          coefCnt_d = coefCnt_q;
          if (fc_valid) begin
            if (coefCnt_q == TW'(NTAP - 1)) begin
              coefCnt_d = '0;
              state_d   = FETCH;
            end else begin
              coefCnt_d = coefCnt_q + 1'b1;
            end
          end
        end
      end
      FETCH: begin
        if (!start) begin
          state_d = IDLE;
        end else if (drain_q) begin
          state_d = DONE;
        end else begin
          xCnt_d   = xCnt_q;
          yCnt_d   = yCnt_q;
          mCnt_d   = mCnt_q;
          nCnt_d   = nCnt_q + 1'b1;
          tapCnt_d = tapCnt_q + 1'b1;
          if (nCnt_q == MW'(K - 1)) begin
            nCnt_d = '0;
            if (mCnt_q == MW'(K - 1)) begin
              mCnt_d   = '0;
              tapCnt_d = '0;
              if (xCnt_q == XW'(IMG_W - 1)) begin
                xCnt_d = '0;
                if (yCnt_q == YW'(IMG_H - 1)) begin
                  yCnt_d  = '0;
                  drain_d = 1'b1;
                end else begin
                  yCnt_d = yCnt_q + 1'b1;
                end
              end else begin
                xCnt_d = xCnt_q + 1'b1;
              end
            end else begin
              mCnt_d = mCnt_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Coefficient slots, written in raster order while loading and kept between runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAP; i++) begin
        coef_q[i] <= '0;
      end
    end else if ((state_q == LOAD_COEF) && start && fc_valid) begin
      coef_q[coefCnt_q] <= fc;
    end
  end

  // Window pipeline stage aligned with the SRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winValid_q <= 1'b0;
      winFirst_q <= 1'b0;
      winLast_q  <= 1'b0;
      winCoef_q  <= '0;
      outX_q     <= '0;
      outY_q     <= '0;
    end else begin
      winValid_q <= issue;
      winFirst_q <= issue && (tapCnt_q == '0);
      winLast_q  <= issue && (tapCnt_q == TW'(NTAP - 1));
      if (issue) begin
        winCoef_q <= coef_q[tapCnt_q];
        outX_q    <= xCnt_q;
        outY_q    <= yCnt_q;
      end
    end
  end

  assign win_valid = winValid_q;
  assign win_first = winFirst_q;
  assign win_last  = winLast_q;
  assign win_coef  = winCoef_q;
  assign out_x     = outX_q;
  assign out_y     = outY_q;
  assign busy      = (state_q == LOAD_COEF) || (state_q == FETCH);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Testbench for conv_seq_ctrl on an 8x4 image with a 3x3 kernel.
// Expected taps are queued when a run is started and a negedge monitor
// pops and compares them whenever win_valid is presented.
module tb_conv_seq_ctrl;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int K     = 3;
  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int AW    = 5;
  localparam int NTAP  = K * K;
  localparam int NRUN  = IMG_W * IMG_H * NTAP;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 fc_valid;
  logic signed [CW-1:0] fc;
  logic                 sram_rd;
  logic [AW-1:0]        sram_addr;
  logic [DW-1:0]        sram_rdata;
  logic                 win_valid;
  logic [DW-1:0]        win_pixel;
  logic signed [CW-1:0] win_coef;
  logic                 win_first;
  logic                 win_last;
  logic [2:0]           out_x;
  logic [1:0]           out_y;
  logic                 busy;
  logic                 done;

  typedef struct {
    int pix;
    int coef;
    bit first;
    bit last;
    int x;
    int y;
    int t;
    bit rd;
  } tap_t;

  tap_t expQ[$];
  tap_t e;

  int nVectors     = 0;
  int nMiscompares = 0;
  int tapsSeen     = 0;
  bit captureOn    = 0;
  bit prevRd       = 0;
  int capPix   [NRUN];
  bit capFirst [NRUN];
  bit capLast  [NRUN];

  logic signed [CW-1:0] coefSet [0:2][0:NTAP-1] = '{
    '{8'sd3, -8'sd2, 8'sd5, -8'sd7, 8'sd24, 8'sd1, -8'sd128, 8'sd127, -8'sd1},
    '{8'sd10, 8'sd20, 8'sd30, 8'sd40, 8'sd50, 8'sd60, 8'sd70, 8'sd80, 8'sd90},
    '{-8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd24, -8'sd1, -8'sd1, -8'sd1, -8'sd1}
  };

  int handCenter [NTAP] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
`ifdef CONV_ZEROPAD_EN
  int handCorner [NTAP] = '{0, 0, 0, 0, 0, 1, 0, 8, 9};
`else
  int handCorner [NTAP] = '{0, 0, 1, 0, 0, 1, 8, 8, 9};
`endif

  conv_seq_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DW(DW), .CW(CW), .AW(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .fc_valid  (fc_valid),
    .fc        (fc),
    .sram_rd   (sram_rd),
    .sram_addr (sram_addr),
    .sram_rdata(sram_rdata),
    .win_valid (win_valid),
    .win_pixel (win_pixel),
    .win_coef  (win_coef),
    .win_first (win_first),
    .win_last  (win_last),
    .out_x     (out_x),
    .out_y     (out_y),
    .busy      (busy),
    .done      (done)
  );

  // 100 MHz style clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM whose content equals its address; idle cycles return a marker value.
  always @(posedge clk) begin
    if (sram_rd) sram_rdata <= DW'(sram_addr);
    else         sram_rdata <= 8'hEE;
  end

  // Reference tap: source clamped (or zero-padded) around output pixel (y,x).
  function automatic tap_t modelTap(input int y, input int x, input int m,
                                    input int n, input int setIdx);
    tap_t r;
    int row, col, rc, cc;
    bit oob;
    row = y + m - K / 2;
    col = x + n - K / 2;
    oob = (row < 0) || (row > IMG_H - 1) || (col < 0) || (col > IMG_W - 1);
    rc  = (row < 0) ? 0 : ((row > IMG_H - 1) ? IMG_H - 1 : row);
    cc  = (col < 0) ? 0 : ((col > IMG_W - 1) ? IMG_W - 1 : col);
`ifdef CONV_ZEROPAD_EN
    r.pix = oob ? 0 : rc * IMG_W + cc;
    r.rd  = !oob;
`else
    r.pix = rc * IMG_W + cc;
    r.rd  = 1'b1;
`endif
    r.coef  = int'(coefSet[setIdx][m * K + n]);
    r.first = (m == 0) && (n == 0);
    r.last  = (m == K - 1) && (n == K - 1);
    r.x     = x;
    r.y     = y;
    r.t     = m * K + n;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Start a run from IDLE: queue the first nExpect taps, then load coefficients
  // with 'gap' idle cycles between strobes. Returns just after the edge that
  // accepts the last coefficient.
  task automatic applyStimulus(input int setIdx, input int gap, input int nExpect);
    int cnt = 0;
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        for (int m = 0; m < K; m++)
          for (int n = 0; n < K; n++) begin
            if (cnt < nExpect) expQ.push_back(modelTap(y, x, m, n, setIdx));
            cnt++;
          end
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < NTAP; c++) begin
      fc       = coefSet[setIdx][c];
      fc_valid = 1'b1;
      @(posedge clk); #1;
      fc_valid = 1'b0;
      if (c != NTAP - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_reached", int'(done === 1'b1), 1);
  endtask

  // Scoreboard monitor: every presented tap must match the head of the queue.
  always @(negedge clk) begin
    if (win_valid === 1'b1) begin
      tapsSeen++;
      nVectors++;
      if (expQ.size() == 0) begin
        nMiscompares++;
        $display("[TB] FAIL unexpected_tap: got tap at y=%0d x=%0d pix=%0d, required none",
                 out_y, out_x, win_pixel);
      end else begin
        e = expQ.pop_front();
        if (win_pixel !== DW'(e.pix) || int'(win_coef) !== e.coef ||
            win_first !== e.first || win_last !== e.last ||
            int'(out_x) !== e.x || int'(out_y) !== e.y || prevRd !== e.rd) begin
          nMiscompares++;
          $display("[TB] FAIL tap_y%0d_x%0d_t%0d: got pix=%0d coef=%0d first=%0b last=%0b x=%0d y=%0d rd=%0b, required pix=%0d coef=%0d first=%0b last=%0b x=%0d y=%0d rd=%0b",
                   e.y, e.x, e.t, win_pixel, win_coef, win_first, win_last, out_x, out_y,
                   prevRd, e.pix, e.coef, e.first, e.last, e.x, e.y, e.rd);
        end
        if (captureOn) begin
          capPix[(e.y * IMG_W + e.x) * NTAP + e.t]   = int'(win_pixel);
          capFirst[(e.y * IMG_W + e.x) * NTAP + e.t] = win_first;
          capLast[(e.y * IMG_W + e.x) * NTAP + e.t]  = win_last;
        end
      end
    end
    prevRd = sram_rd;
  end

  initial begin
    for (int i = 0; i < NRUN; i++) capPix[i] = -1;
    rst_n    = 1'b0;
    start    = 1'b0;
    fc_valid = 1'b0;
    fc       = '0;
    #2;
    checkOutput("rst_sram_rd",   int'(sram_rd),   0);
    checkOutput("rst_sram_addr", int'(sram_addr), 0);
    checkOutput("rst_win_valid", int'(win_valid), 0);
    checkOutput("rst_win_pixel", int'(win_pixel), 0);
    checkOutput("rst_win_coef",  int'(win_coef),  0);
    checkOutput("rst_win_first", int'(win_first), 0);
    checkOutput("rst_win_last",  int'(win_last),  0);
    checkOutput("rst_out_x",     int'(out_x),     0);
    checkOutput("rst_out_y",     int'(out_y),     0);
    checkOutput("rst_busy",      int'(busy),      0);
    checkOutput("rst_done",      int'(done),      0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] run A: gapped coefficient load, stray fc_valid during fetch");
    tapsSeen  = 0;
    captureOn = 1'b1;
    applyStimulus(0, 2, NRUN);
    repeat (5) begin
      fc = 8'sd99; fc_valid = 1'b1;
      @(posedge clk); #1;
      fc_valid = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("runA_busy_fetch", int'(busy), 1);
    waitDone(400);
    captureOn = 1'b0;
    checkOutput("runA_busy_done", int'(busy), 0);
    checkOutput("runA_tap_count", tapsSeen, NRUN);
    checkOutput("runA_queue_left", expQ.size(), 0);
    for (int t = 0; t < NTAP; t++) begin
      checkOutput($sformatf("center_pix_t%0d", t), capPix[(1 * IMG_W + 1) * NTAP + t], handCenter[t]);
      checkOutput($sformatf("corner_pix_t%0d", t), capPix[t], handCorner[t]);
    end
    checkOutput("center_first_t0", int'(capFirst[(1 * IMG_W + 1) * NTAP]), 1);
    checkOutput("center_last_t8",  int'(capLast[(1 * IMG_W + 1) * NTAP + NTAP - 1]), 1);
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("runA_done_cleared", int'(done), 0);

    $display("[TB] run B: start dropped at tap 40");
    tapsSeen = 0;
    applyStimulus(1, 0, 40);
    repeat (40) @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_win_valid", int'(win_valid), 0);
    checkOutput("abort_sram_rd",   int'(sram_rd),   0);
    checkOutput("abort_busy",      int'(busy),      0);
    checkOutput("abort_done",      int'(done),      0);
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("abort_tap_count", tapsSeen, 40);
    checkOutput("abort_queue_left", expQ.size(), 0);

    $display("[TB] run C: restart with full run");
    tapsSeen = 0;
    applyStimulus(2, 0, NRUN);
    waitDone(400);
    checkOutput("runC_tap_count", tapsSeen, NRUN);
    checkOutput("runC_queue_left", expQ.size(), 0);
    start = 1'b0;
    @(posedge clk); #1;

    $display("[TB] run D: asynchronous reset mid-fetch");
    applyStimulus(0, 1, 19);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_win_valid", int'(win_valid), 0);
    checkOutput("arst_sram_rd",   int'(sram_rd),   0);
    checkOutput("arst_sram_addr", int'(sram_addr), 0);
    checkOutput("arst_win_pixel", int'(win_pixel), 0);
    checkOutput("arst_win_coef",  int'(win_coef),  0);
    checkOutput("arst_win_first", int'(win_first), 0);
    checkOutput("arst_win_last",  int'(win_last),  0);
    checkOutput("arst_out_x",     int'(out_x),     0);
    checkOutput("arst_out_y",     int'(out_y),     0);
    checkOutput("arst_busy",      int'(busy),      0);
    checkOutput("arst_done",      int'(done),      0);
    start = 1'b0;
    #13 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("arst_queue_left", expQ.size(), 0);
    checkOutput("arst_busy_after", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
